// File: rtl/weight_mac_bank_cell.sv
// Systolic weight MAC cell: NEURONS parallel dot-product lanes over a streamed (index,value)
// vector, with a result bank that drains into free slots of the shared result chain.

module weight_mac_lane #(
  parameter int DATA_WIDTH    = 16,
  parameter int RESULT_WIDTH  = 32,
  parameter int WEIGHT_AMOUNT = 2,
  parameter int IW            = 1,
  parameter logic [WEIGHT_AMOUNT*DATA_WIDTH-1:0] INIT_ROW = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    last,
  input  logic [DATA_WIDTH-1:0]   index,
  input  logic [DATA_WIDTH-1:0]   value,
  input  logic                    wr_en,
  input  logic [IW-1:0]           wr_index,
  input  logic [DATA_WIDTH-1:0]   wr_value,
  output logic [RESULT_WIDTH-1:0] sum
);
  logic [WEIGHT_AMOUNT-1:0][DATA_WIDTH-1:0] w;
  logic [RESULT_WIDTH-1:0]                  acc;
  logic [2*DATA_WIDTH-1:0]                  prod_full;

  // Out-of-range indices contribute nothing rather than aliasing onto a real weight.
  always_comb begin
    prod_full = '0;
    if (index < DATA_WIDTH'(WEIGHT_AMOUNT))
      prod_full = value * w[index[IW-1:0]];
    sum = acc + RESULT_WIDTH'(prod_full);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
      w   <= INIT_ROW;
    end else begin
      if (en)
        acc <= last ? '0 : sum;
      if (wr_en)
        w[wr_index] <= wr_value;
    end
  end
endmodule

module weight_mac_bank_cell #(
  parameter int DATA_WIDTH    = 16,
  parameter int RESULT_WIDTH  = 32,
  parameter int WEIGHT_AMOUNT = 2,
  parameter int NEURONS       = 2,
  parameter logic [NEURONS*WEIGHT_AMOUNT*DATA_WIDTH-1:0] INIT_WEIGHTS = '0,
  localparam int NW = (NEURONS > 1) ? $clog2(NEURONS) : 1,
  localparam int IW = (WEIGHT_AMOUNT > 1) ? $clog2(WEIGHT_AMOUNT) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATA_WIDTH-1:0]   input_index,
  input  logic [DATA_WIDTH-1:0]   input_value,
  input  logic                    input_last,
  input  logic                    input_enable,
  input  logic [RESULT_WIDTH:0]   input_result,
  input  logic                    wload_enable,
  input  logic [NW-1:0]           wload_neuron,
  input  logic [IW-1:0]           wload_index,
  input  logic [DATA_WIDTH-1:0]   wload_value,
  output logic [DATA_WIDTH-1:0]   output_index,
  output logic [DATA_WIDTH-1:0]   output_value,
  output logic                    output_last,
  output logic                    output_enable,
  output logic [RESULT_WIDTH:0]   output_result,
  output logic                    overflow
);
  localparam int NWX = NW + 1;
  localparam int IWX = IW + 1;
  localparam int ROW = WEIGHT_AMOUNT * DATA_WIDTH;

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t                                state;
  logic [NW-1:0]                         ptr;
  logic [NEURONS-1:0][RESULT_WIDTH-1:0]  sum;
  logic [NEURONS-1:0][RESULT_WIDTH-1:0]  bank;
  logic [NEURONS-1:0]                    wr_row;
  logic                                  chain_busy, pop, pop_last, complete, accept;

  always_comb begin
    wr_row = '0;
    if (wload_enable && NWX'(wload_neuron) < NWX'(NEURONS)
                     && IWX'(wload_index) < IWX'(WEIGHT_AMOUNT))
      wr_row[wload_neuron] = 1'b1;
  end

  for (genvar n = 0; n < NEURONS; n++) begin : g_lane
    weight_mac_lane #(
      .DATA_WIDTH   (DATA_WIDTH),
      .RESULT_WIDTH (RESULT_WIDTH),
      .WEIGHT_AMOUNT(WEIGHT_AMOUNT),
      .IW           (IW),
      .INIT_ROW     (INIT_WEIGHTS[n*ROW +: ROW])
    ) u_lane (
      .clk     (clk),
      .reset   (reset),
      .en      (input_enable),
      .last    (input_last),
      .index   (input_index),
      .value   (input_value),
      .wr_en   (wr_row[n]),
      .wr_index(wload_index),
      .wr_value(wload_value),
      .sum     (sum[n])
    );
  end

  // A completion is accepted if the bank is empty or its final entry leaves on this same edge.
  assign chain_busy = input_result[RESULT_WIDTH];
  assign pop        = (state == DRAIN) && !chain_busy;
  assign pop_last   = pop && (ptr == NW'(NEURONS - 1));
  assign complete   = input_enable && input_last;
  assign accept     = complete && ((state == IDLE) || pop_last);

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      ptr           <= '0;
      bank          <= '0;
      output_result <= '0;
      overflow      <= 1'b0;
      output_index  <= '0;
      output_value  <= '0;
      output_last   <= 1'b0;
      output_enable <= 1'b0;
    end else begin
      output_index  <= input_index;
      output_value  <= input_value;
      output_last   <= input_last;
      output_enable <= input_enable;

      if (chain_busy)
        output_result <= input_result;
      else if (pop)
        output_result <= {1'b1, bank[ptr]};
      else
        output_result <= '0;

      if (accept) begin
        bank  <= sum;
        ptr   <= '0;
        state <= DRAIN;
      end else if (pop) begin
        ptr <= ptr + 1'b1;
        if (pop_last)
          state <= IDLE;
      end

      if (complete && !accept)
        overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_weight_mac_bank_cell.sv
// Bench for weight_mac_bank_cell: directed scenarios then random traffic, checked every
// cycle against a queue-based reference model of the cell.

module tb_weight_mac_bank_cell;
  localparam logic [63:0] INIT = {16'd3, 16'd2, 16'd4, 16'd1};

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] input_index, input_value;
  logic        input_last, input_enable;
  logic [32:0] input_result;
  logic        wload_enable;
  logic [0:0]  wload_neuron, wload_index;
  logic [15:0] wload_value;
  logic [15:0] output_index, output_value;
  logic        output_last, output_enable;
  logic [32:0] output_result;
  logic        overflow;

  weight_mac_bank_cell #(
    .DATA_WIDTH(16), .RESULT_WIDTH(32), .WEIGHT_AMOUNT(2), .NEURONS(2), .INIT_WEIGHTS(INIT)
  ) dut (
    .clk(clk), .reset(reset),
    .input_index(input_index), .input_value(input_value),
    .input_last(input_last), .input_enable(input_enable),
    .input_result(input_result),
    .wload_enable(wload_enable), .wload_neuron(wload_neuron),
    .wload_index(wload_index), .wload_value(wload_value),
    .output_index(output_index), .output_value(output_value),
    .output_last(output_last), .output_enable(output_enable),
    .output_result(output_result), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // reference model state
  logic [15:0] mw [2][2];
  logic [31:0] macc [2];
  logic [31:0] q [$];
  logic [15:0] e_idx, e_val;
  logic        e_last, e_en, e_ovf;
  logic [32:0] e_res;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mw[0][0] = 16'd1; mw[0][1] = 16'd4; mw[1][0] = 16'd2; mw[1][1] = 16'd3;
    macc[0] = '0; macc[1] = '0;
    q.delete();
    e_idx = '0; e_val = '0; e_last = 1'b0; e_en = 1'b0; e_res = '0; e_ovf = 1'b0;
  endtask

  // One clock edge: advance the model with the inputs present at the edge, then compare.
  task automatic tick();
    logic [31:0] prod [2];
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else begin
      for (int n = 0; n < 2; n++)
        prod[n] = (input_index < 16'd2) ? 32'(input_value) * 32'(mw[n][input_index[0]]) : 32'd0;
      if (input_result[32])
        e_res = input_result;
      else if (q.size() != 0)
        e_res = {1'b1, q.pop_front()};
      else
        e_res = '0;
      if (input_enable) begin
        for (int n = 0; n < 2; n++) macc[n] = macc[n] + prod[n];
        if (input_last) begin
          if (q.size() == 0) begin
            for (int n = 0; n < 2; n++) q.push_back(macc[n]);
          end else begin
            e_ovf = 1'b1;
          end
          for (int n = 0; n < 2; n++) macc[n] = '0;
        end
      end
      if (wload_enable) mw[wload_neuron][wload_index] = wload_value;
      e_idx = input_index; e_val = input_value; e_last = input_last; e_en = input_enable;
    end
    #1;
    chk("output_index", 64'(output_index), 64'(e_idx));
    chk("output_value", 64'(output_value), 64'(e_val));
    chk("output_last", 64'(output_last), 64'(e_last));
    chk("output_enable", 64'(output_enable), 64'(e_en));
    chk("output_result", 64'(output_result), 64'(e_res));
    chk("overflow", 64'(overflow), 64'(e_ovf));
  endtask

  task automatic drive(input logic en, input logic lst, input logic [15:0] idx,
                       input logic [15:0] val);
    input_enable = en; input_last = lst; input_index = idx; input_value = val;
  endtask

  initial begin
    reset = 1'b1; drive(0, 0, 0, 0); input_result = '0;
    wload_enable = 1'b0; wload_neuron = '0; wload_index = '0; wload_value = '0;
    model_reset();

    // 1: reset then idle
    tick(); tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t1_idle_result", 64'(output_result), 64'd0);
    end

    // 2: single vector, free chain
    drive(1, 0, 0, 3); tick();
    chk("t2_pass_value", 64'(output_value), 64'd3);
    drive(1, 1, 1, 4); tick();
    drive(0, 0, 0, 0); tick();
    chk("t2_n0", 64'(output_result), {31'd0, 1'b1, 32'd19});
    tick();
    chk("t2_n1", 64'(output_result), {31'd0, 1'b1, 32'd18});
    tick();
    chk("t2_empty", 64'(output_result), 64'd0);

    // 3: upstream results take priority over bank drain
    drive(1, 0, 0, 3); tick();
    drive(1, 1, 1, 4); tick();
    drive(0, 0, 0, 0);
    input_result = {1'b1, 32'd55}; tick();
    chk("t3_up55", 64'(output_result), {31'd0, 1'b1, 32'd55});
    input_result = {1'b1, 32'd45}; tick();
    chk("t3_up45", 64'(output_result), {31'd0, 1'b1, 32'd45});
    input_result = '0; tick();
    chk("t3_n0", 64'(output_result), {31'd0, 1'b1, 32'd19});
    tick();
    chk("t3_n1", 64'(output_result), {31'd0, 1'b1, 32'd18});
    tick();

    // 4: second vector completes while the bank is still draining
    drive(1, 0, 0, 3); tick();
    drive(1, 1, 1, 4); tick();
    drive(1, 1, 1, 2); tick();
    chk("t4_overflow", 64'(overflow), 64'd1);
    chk("t4_n0", 64'(output_result), {31'd0, 1'b1, 32'd19});
    drive(0, 0, 0, 0); tick();
    chk("t4_n1", 64'(output_result), {31'd0, 1'b1, 32'd18});
    tick();
    chk("t4_dropped", 64'(output_result), 64'd0);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("t4_ovf_cleared", 64'(overflow), 64'd0);

    // 5: weight write on the same edge as a compute uses the old weight
    drive(1, 1, 1, 2);
    wload_enable = 1'b1; wload_neuron = 1'b0; wload_index = 1'b1; wload_value = 16'd10;
    tick();
    wload_enable = 1'b0; drive(0, 0, 0, 0); tick();
    chk("t5_old_w", 64'(output_result), {31'd0, 1'b1, 32'd8});
    tick(); tick();
    drive(1, 1, 1, 2); tick();
    drive(0, 0, 0, 0); tick();
    chk("t5_new_w", 64'(output_result), {31'd0, 1'b1, 32'd20});
    tick();
    chk("t5_n1", 64'(output_result), {31'd0, 1'b1, 32'd6});
    tick();

    // 6: reset mid-vector discards the partial sum and restores weights
    drive(1, 0, 0, 3); reset = 1'b1; tick();
    chk("t6_reset_result", 64'(output_result), 64'd0);
    reset = 1'b0;
    drive(1, 1, 1, 4); tick();
    drive(0, 0, 0, 0); tick();
    chk("t6_n0", 64'(output_result), {31'd0, 1'b1, 32'd16});
    tick();
    chk("t6_n1", 64'(output_result), {31'd0, 1'b1, 32'd12});
    tick();

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 59) == 0);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
            16'($urandom_range(0, 2)), 16'($urandom));
      input_result = {($urandom_range(0, 2) == 0), 32'($urandom)};
      wload_enable = ($urandom_range(0, 7) == 0);
      wload_neuron = 1'($urandom); wload_index = 1'($urandom); wload_value = 16'($urandom);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
